// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// A single carry flip-flop is reused for every bit position, so the datapath
// is one full-adder cell plus three shift registers.
//
// Handshake: start is sampled on a rising edge only while the block is free
// (IDLE or DONE); an accepted start latches a, b and cin on that same edge.
// busy is high for the WIDTH cycles in which bits are processed. done is a
// single-cycle pulse that follows the last SHIFT cycle. sum/cout are valid
// from the done cycle until the next accepted start. A start seen while busy
// is dropped, never queued.
`timescale 1ns/1ps

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sreg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             bit_s;
    logic             bit_c;

    // Full-adder cell applied to the current LSBs and the running carry.
    assign bit_s    = ra[0] ^ rb[0] ^ carry;
    assign bit_c    = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; load marks an accepting edge (from IDLE or DONE).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, carry and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            ra    <= a;
            rb    <= b;
            sreg  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            ra    <= {1'b0, ra[WIDTH-1:1]};
            rb    <= {1'b0, rb[WIDTH-1:1]};
            sreg  <= {bit_s, sreg[WIDTH-1:1]};
            carry <= bit_c;
            // Hold on the final bit so the counter never wraps.
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign sum       = sreg;
    assign cout      = carry;
    assign state_dbg = state;

endmodule
